// File: rtl/bucket_timer_pkg.sv
// Shared types and width helpers for the multi-channel bucket rotation timer.
package bucket_timer_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 1) ? value - 1 : 0;
    while (rem != 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Channel select width; a single channel still needs a 1-bit select port.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer slice: tick counter, programmable period/mode, rotating bucket index
// and sticky one-shot expiry flag.
module timer_channel
  import bucket_timer_pkg::*;
#(
  parameter int unsigned      CNT_W          = 32,
  parameter int unsigned      NUM_BUCKETS    = 4,
  parameter int unsigned      BKT_W          = 2,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             enable,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_period,
  input  mode_e            cfg_mode,
  input  logic             force_update,
  output logic             update,
  output logic [BKT_W-1:0] bucket_idx,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  mode_e            mode;

  logic             counting_c;
  logic             terminal_c;
  logic             fire_c;
  logic [BKT_W-1:0] bucket_next_c;

  // A config write on the terminal cycle suppresses the terminal update; force always fires.
  always_comb begin
    counting_c    = tick & enable & (period != '0) & ~expired;
    terminal_c    = counting_c & (cnt == period - CNT_W'(1));
    fire_c        = force_update | (terminal_c & ~cfg_sel);
    bucket_next_c = (bucket_idx == BKT_W'(NUM_BUCKETS - 1)) ? '0 : bucket_idx + BKT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      period     <= DEFAULT_PERIOD;
      mode       <= MODE_PERIODIC;
      update     <= 1'b0;
      bucket_idx <= '0;
      expired    <= 1'b0;
    end else begin
      update <= fire_c;
      if (fire_c) begin
        bucket_idx <= bucket_next_c;
      end
      if (cfg_sel) begin
        period  <= cfg_period;
        mode    <= cfg_mode;
        cnt     <= '0;
        expired <= 1'b0;
      end else if (terminal_c) begin
        cnt <= '0;
        if (mode == MODE_ONESHOT) begin
          expired <= 1'b1;
        end
      end else if (force_update) begin
        cnt <= '0;
      end else if (counting_c) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bucket_rotation_timer.sv
// Multi-channel Bloom-filter bucket rotation timer: shared tick prescaler, config
// decode and one timer_channel per channel.
module bucket_rotation_timer
  import bucket_timer_pkg::*;
#(
  parameter int unsigned      NUM_CH         = 4,
  parameter int unsigned      CNT_W          = 32,
  parameter int unsigned      PRESCALE_W     = 8,
  parameter int unsigned      NUM_BUCKETS    = 4,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(32'h3fff_ffff)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_CH-1:0]                        enable,
  input  logic [PRESCALE_W-1:0]                    prescale,
  input  logic                                     cfg_wr,
  input  logic [ch_width(NUM_CH)-1:0]              cfg_ch,
  input  logic [CNT_W-1:0]                         cfg_period,
  input  logic                                     cfg_oneshot,
  input  logic [NUM_CH-1:0]                        force_update,
  output logic [NUM_CH-1:0]                        update,
  output logic [NUM_CH*clog2(NUM_BUCKETS)-1:0]     bucket_idx,
  output logic [NUM_CH-1:0]                        expired
);

  localparam int unsigned CH_W     = ch_width(NUM_CH);
  localparam int unsigned CH_CMP_W = CH_W + 1;
  localparam int unsigned BKT_W    = clog2(NUM_BUCKETS);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick_c;
  logic                  cfg_valid_c;
  mode_e                 cfg_mode_c;

  // Compare with >= so lowering prescale below pre_cnt ticks next cycle instead of wrapping.
  always_comb begin
    tick_c      = (pre_cnt >= prescale);
    cfg_valid_c = cfg_wr & ({1'b0, cfg_ch} < CH_CMP_W'(NUM_CH));
    cfg_mode_c  = mode_e'(cfg_oneshot);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_sel_c;

    always_comb begin
      cfg_sel_c = cfg_valid_c & (cfg_ch == CH_W'(i));
    end

    timer_channel #(
      .CNT_W         (CNT_W),
      .NUM_BUCKETS   (NUM_BUCKETS),
      .BKT_W         (BKT_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_channel (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick_c),
      .enable      (enable[i]),
      .cfg_sel     (cfg_sel_c),
      .cfg_period  (cfg_period),
      .cfg_mode    (cfg_mode_c),
      .force_update(force_update[i]),
      .update      (update[i]),
      .bucket_idx  (bucket_idx[i*BKT_W +: BKT_W]),
      .expired     (expired[i])
    );
  end

endmodule

// File: tb/tb_bucket_rotation_timer.sv
// Self-checking bench for bucket_rotation_timer: vector table, directed corner
// sequences and randomized traffic against a behavioural channel model.
module tb_bucket_rotation_timer;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;
  localparam int PRE_W  = 4;
  localparam int NB     = 4;
  localparam int BKT_W  = 2;
  localparam int CH_W   = 3;
  localparam int DEF_P  = 12;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b1;
  logic [NUM_CH-1:0]       enable = '0;
  logic [PRE_W-1:0]        prescale = '0;
  logic                    cfg_wr = 1'b0;
  logic [CH_W-1:0]         cfg_ch = '0;
  logic [CNT_W-1:0]        cfg_period = '0;
  logic                    cfg_oneshot = 1'b0;
  logic [NUM_CH-1:0]       force_update = '0;
  logic [NUM_CH-1:0]       update;
  logic [NUM_CH*BKT_W-1:0] bucket_idx;
  logic [NUM_CH-1:0]       expired;

  int tests = 0;
  int fails = 0;

  bucket_rotation_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE_W(PRE_W), .NUM_BUCKETS(NB),
    .DEFAULT_PERIOD(16'(DEF_P))
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .prescale(prescale),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_oneshot(cfg_oneshot), .force_update(force_update),
    .update(update), .bucket_idx(bucket_idx), .expired(expired)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel tick counts, period, mode, bucket and expiry.
  int unsigned m_pre;
  int unsigned m_cnt [NUM_CH];
  int unsigned m_per [NUM_CH];
  bit          m_one [NUM_CH];
  int          m_bkt [NUM_CH];
  bit          m_exp [NUM_CH];
  bit          m_upd [NUM_CH];

  task automatic model_reset();
    m_pre = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_per[c] = DEF_P; m_one[c] = 0;
      m_bkt[c] = 0; m_exp[c] = 0; m_upd[c] = 0;
    end
  endtask

  task automatic model_step();
    bit tick, wr, run, term, fire;
    tick  = (m_pre >= int'(prescale));
    m_pre = tick ? 0 : m_pre + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      wr   = cfg_wr && (int'(cfg_ch) == c);
      run  = tick && enable[c] && (m_per[c] != 0) && !m_exp[c];
      term = run && (m_cnt[c] + 1 == m_per[c]);
      fire = force_update[c] || (term && !wr);
      m_upd[c] = fire;
      if (fire) m_bkt[c] = (m_bkt[c] + 1) % NB;
      if (wr) begin
        m_per[c] = int'(cfg_period); m_one[c] = cfg_oneshot;
        m_cnt[c] = 0; m_exp[c] = 0;
      end else if (fire) begin
        m_cnt[c] = 0;
        if (term && m_one[c]) m_exp[c] = 1;
      end else if (run) begin
        m_cnt[c] = m_cnt[c] + 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    logic [NUM_CH-1:0]       eu, ee;
    logic [NUM_CH*BKT_W-1:0] eb;
    for (int c = 0; c < NUM_CH; c++) begin
      eu[c] = m_upd[c];
      ee[c] = m_exp[c];
      eb[c*BKT_W +: BKT_W] = BKT_W'(m_bkt[c]);
    end
    check({tag, ".update"}, 32'(update), 32'(eu));
    check({tag, ".bucket"}, 32'(bucket_idx), 32'(eb));
    check({tag, ".expired"}, 32'(expired), 32'(ee));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model("model");
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".update"}, 32'(update), 32'd0);
    check({tag, ".bucket"}, 32'(bucket_idx), 32'd0);
    check({tag, ".expired"}, 32'(expired), 32'd0);
  endtask

  // Asynchronous reset taken between edges; outputs must clear before the next edge.
  task automatic reset_seq(input string tag);
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    enable = '0; cfg_wr = 1'b0; force_update = '0; prescale = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_pulse(input int ch, input int bound, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!update[ch] && cycles < bound);
    if (!update[ch]) begin
      fails++;
      tests++;
      $display("FAIL wait_pulse ch%0d: no update within %0d cycles", ch, bound);
    end
  endtask

  typedef struct {
    logic            wr;
    logic [CH_W-1:0] ch;
    logic [CNT_W-1:0] per;
    logic            one;
    logic            en0;
    logic            frc0;
    logic [NUM_CH-1:0]       e_upd;
    logic [NUM_CH*BKT_W-1:0] e_bkt;
    logic [NUM_CH-1:0]       e_exp;
  } vec_t;

  vec_t vecs [23];

  initial begin
    int gap, extra;

    // wr ch per one en frc | update bucket expired
    vecs[0]  = '{1, 0, 3, 0, 1, 0, 5'd0, 10'd0, 5'd0};
    vecs[1]  = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd0, 5'd0};
    vecs[2]  = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd0, 5'd0};
    vecs[3]  = '{0, 0, 3, 0, 1, 0, 5'd1, 10'd1, 5'd0};
    vecs[4]  = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd1, 5'd0};
    vecs[5]  = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd1, 5'd0};
    vecs[6]  = '{0, 0, 3, 0, 1, 0, 5'd1, 10'd2, 5'd0};
    vecs[7]  = '{0, 0, 3, 0, 1, 1, 5'd1, 10'd3, 5'd0};
    vecs[8]  = '{0, 0, 3, 0, 0, 0, 5'd0, 10'd3, 5'd0};
    vecs[9]  = '{0, 0, 3, 0, 0, 1, 5'd1, 10'd0, 5'd0};
    vecs[10] = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd0, 5'd0};
    vecs[11] = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd0, 5'd0};
    vecs[12] = '{1, 0, 3, 1, 1, 0, 5'd0, 10'd0, 5'd0};
    vecs[13] = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd0, 5'd0};
    vecs[14] = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd0, 5'd0};
    vecs[15] = '{0, 0, 3, 0, 1, 0, 5'd1, 10'd1, 5'd1};
    vecs[16] = '{0, 0, 3, 0, 1, 0, 5'd0, 10'd1, 5'd1};
    vecs[17] = '{0, 0, 3, 0, 1, 1, 5'd1, 10'd2, 5'd1};
    vecs[18] = '{1, 5, 1, 0, 1, 0, 5'd0, 10'd2, 5'd1};
    vecs[19] = '{1, 0, 1, 0, 1, 0, 5'd0, 10'd2, 5'd0};
    vecs[20] = '{0, 0, 1, 0, 1, 0, 5'd1, 10'd3, 5'd0};
    vecs[21] = '{0, 0, 1, 0, 1, 0, 5'd1, 10'd0, 5'd0};
    vecs[22] = '{0, 0, 1, 0, 0, 0, 5'd0, 10'd0, 5'd0};

    #2;
    reset_seq("reset0");

    for (int i = 0; i < 23; i++) begin
      cfg_wr = vecs[i].wr; cfg_ch = vecs[i].ch; cfg_period = vecs[i].per;
      cfg_oneshot = vecs[i].one; enable = {4'b0, vecs[i].en0};
      force_update = {4'b0, vecs[i].frc0};
      step();
      check($sformatf("vec%0d.update", i), 32'(update), 32'(vecs[i].e_upd));
      check($sformatf("vec%0d.bucket", i), 32'(bucket_idx), 32'(vecs[i].e_bkt));
      check($sformatf("vec%0d.expired", i), 32'(expired), 32'(vecs[i].e_exp));
    end
    cfg_wr = 1'b0; force_update = '0; enable = '0;

    // Prescaled channel: steady gap, then a 12-clock enable stall stretches one gap.
    reset_seq("reset1");
    prescale = 4'd3;
    cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_period = 16'd2; cfg_oneshot = 1'b0;
    enable = 5'b00010;
    step();
    cfg_wr = 1'b0;
    wait_pulse(1, 100, gap);
    wait_pulse(1, 100, gap);
    check("t2.gap", 32'(gap), 32'd8);
    enable = '0;
    for (int i = 0; i < 12; i++) step();
    enable = 5'b00010;
    wait_pulse(1, 100, extra);
    check("t2.stall_gap", 32'(extra + 12), 32'd20);

    // Force on the terminal cycle yields a single update.
    reset_seq("reset2");
    cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_period = 16'd3; cfg_oneshot = 1'b0;
    enable = 5'b01000;
    step();
    cfg_wr = 1'b0;
    step();
    step();
    force_update = 5'b01000;
    step();
    check("t4.update", 32'(update), 32'h8);
    check("t4.bucket3", 32'(bucket_idx[7:6]), 32'd1);
    force_update = '0;
    step();
    check("t4.single", 32'(update), 32'h0);
    step();
    step();
    check("t4.next", 32'(update), 32'h8);
    check("t4.bucket3b", 32'(bucket_idx[7:6]), 32'd2);

    // Randomized traffic with an asynchronous reset mid-run.
    reset_seq("reset3");
    enable = '1;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 49) == 0) prescale = PRE_W'($urandom_range(0, 7));
      for (int c = 0; c < NUM_CH; c++) begin
        enable[c]       = ($urandom_range(0, 99) < 85);
        force_update[c] = ($urandom_range(0, 19) == 0);
      end
      cfg_wr      = ($urandom_range(0, 7) == 0);
      cfg_ch      = CH_W'($urandom_range(0, 7));
      cfg_period  = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 6));
      cfg_oneshot = 1'($urandom_range(0, 1));
      step();
      if (n == 1200) begin
        #3;
        reset_seq("reset_mid");
        enable = '1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
